// File: rtl/paralelo_serial_if.sv
// Byte-in / serial-out bundle between the two-lane mux and the serializer.
// The master side drives the byte; the slave side (serializer) drives the serial stream.
interface paralelo_serial_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       frame_start;
  logic       active;

  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  frame_start,
    input  active
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output frame_start,
    output active
  );
endinterface

// File: rtl/paralelo_serial.sv
// MSB-first byte serializer: one byte per 8 clk8f cycles, with idle symbol fill and a
// post-reset warm-up run of idle frames before data is accepted.
module paralelo_serial #(
  parameter logic [7:0]  IDLE_SYM = 8'hBC,
  parameter int unsigned MIN_IDLE = 4
) (
  input logic               clk8f,
  input logic               reset,
  paralelo_serial_if.slave  bus
);

  localparam int unsigned IdleW = $clog2(MIN_IDLE + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(MIN_IDLE - 1);

  typedef enum logic {StWarmup, StActive} state_e;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       sr_q, sr_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             data_out_q, data_out_d;
  logic             frame_start_q, frame_start_d;
  logic             active_q, active_d;
  logic [7:0]       sel;

  always_comb begin
    bit_cnt_d     = bit_cnt_q + 3'd1;
    sr_d          = {sr_q[6:0], 1'b0};
    data_out_d    = sr_q[7];
    frame_start_d = 1'b0;
    active_d      = active_q;
    state_d       = state_q;
    idle_cnt_d    = idle_cnt_q;
    sel           = IDLE_SYM;

    // Load edge: inputs are sampled only here, so mid-frame changes never reach the wire.
    if (bit_cnt_q == 3'd0) begin
      if (state_q == StActive && bus.valid_in) begin
        sel = bus.data_in;
      end
      data_out_d    = sel[7];
      sr_d          = {sel[6:0], 1'b0};
      frame_start_d = 1'b1;

      if (state_q == StWarmup) begin
        idle_cnt_d = idle_cnt_q + IdleW'(1);
        if (idle_cnt_q == IdleLast) begin
          state_d  = StActive;
          active_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      state_q       <= StWarmup;
      bit_cnt_q     <= 3'd0;
      sr_q          <= 8'd0;
      idle_cnt_q    <= '0;
      data_out_q    <= 1'b0;
      frame_start_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      sr_q          <= sr_d;
      idle_cnt_q    <= idle_cnt_d;
      data_out_q    <= data_out_d;
      frame_start_q <= frame_start_d;
      active_q      <= active_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.active      = active_q;

endmodule

// File: tb/tb_paralelo_serial.sv
// Scoreboard bench for paralelo_serial: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_paralelo_serial;

  logic clk8f = 1'b0;
  logic reset;

  paralelo_serial_if bus ();

  paralelo_serial #(
    .IDLE_SYM (8'hBC),
    .MIN_IDLE (4)
  ) dut (
    .clk8f (clk8f),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk8f = ~clk8f;

  typedef struct packed {
    logic d;
    logic fs;
    logic act;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_idx  = 0;
  logic mon_en   = 1'b0;

  // Monitor: one expected entry per cycle, sampled away from the active edge.
  always @(negedge clk8f) begin
    exp_t e;
    exp_t got;
    if (mon_en) begin
      got = '{d: bus.data_out, fs: bus.frame_start, act: bus.active};
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL underflow cyc=%0d got d/fs/act=%b%b%b with nothing expected",
                 cyc_idx, got.d, got.fs, got.act);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL serial cyc=%0d d/fs/act got=%b%b%b exp=%b%b%b",
                   cyc_idx, got.d, got.fs, got.act, e.d, e.fs, e.act);
        end
      end
      cyc_idx++;
    end
  end

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) q.push_back('{d: 1'b0, fs: 1'b0, act: 1'b0});
  endtask

  task automatic push_bits(input logic [7:0] b, input int nbits, input logic act);
    for (int i = 0; i < nbits; i++) begin
      q.push_back('{d: b[7-i], fs: (i == 0), act: act});
    end
  endtask

  // Called just before a load edge; optionally changes data_in after bit 3 is on the wire.
  task automatic send_frame(input logic vld, input logic [7:0] din, input logic [7:0] exp_b,
                            input logic act, input logic mid_chg, input logic [7:0] mid_din);
    bus.valid_in = vld;
    bus.data_in  = din;
    push_bits(exp_b, 8, act);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk8f);
      #1;
      if (mid_chg && i == 2) bus.data_in = mid_din;
    end
  endtask

  task automatic warmup_frames(input logic [7:0] din);
    for (int f = 1; f <= 4; f++) send_frame(1'b1, din, 8'hBC, (f == 4), 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Held in reset with valid data present: everything stays low.
    reset        = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = 8'h11;
    push_zeros(20);
    mon_en = 1'b1;
    repeat (20) @(negedge clk8f);
    #1;

    // Release: next posedge is load edge 1; four idle frames, active rises on edge 25.
    reset = 1'b1;
    warmup_frames(8'hFF);
    send_frame(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00);

    send_frame(1'b1, 8'h13, 8'h13, 1'b1, 1'b0, 8'h00);
    send_frame(1'b1, 8'hFE, 8'hFE, 1'b1, 1'b0, 8'h00);
    send_frame(1'b0, 8'h15, 8'hBC, 1'b1, 1'b0, 8'h00);
    send_frame(1'b1, 8'h17, 8'h17, 1'b1, 1'b0, 8'h00);
    send_frame(1'b1, 8'hF9, 8'hF9, 1'b1, 1'b1, 8'h00);
    send_frame(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);

    // Mid-frame reset during bit 4 of an all-ones frame: outputs must clear without an edge.
    bus.valid_in = 1'b1;
    bus.data_in  = 8'hFF;
    push_bits(8'hFF, 4, 1'b1);
    push_zeros(3);
    repeat (4) @(negedge clk8f);
    @(posedge clk8f);
    #2;
    reset = 1'b0;
    repeat (3) @(negedge clk8f);
    #1;
    reset = 1'b1;

    // Warm-up restarts from scratch before data resumes.
    warmup_frames(8'h11);
    send_frame(1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0, 8'h00);

    mon_en = 1'b0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover expected entries got=%0d exp=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paralelo_serial.md
# paralelo_serial

Serializer stage directly downstream of the two-lane mux. It takes the mux's byte output (8-bit data plus valid) and emits it as a 1-bit MSB-first serial stream, one byte per 8 clock cycles. Whenever the link is not yet active or the input byte is not valid, it transmits the idle/comma symbol instead of data. After every reset it sends a fixed warm-up run of idle symbols before it accepts data.

## Interface
Parameters:
- IDLE_SYM, 8'hBC, symbol sent when no valid data is available or during warm-up.
- MIN_IDLE, 4, number of idle frames sent after reset before data is accepted (≥1).

Ports:
- clk8f  input  1  bit clock; all logic on rising edge (8× the byte rate).
- reset  input  1  asynchronous, active-low; 0 = in reset.
- data_in  input  8  byte from the mux (mux data output).
- valid_in  input  1  byte-valid from the mux (mux valid output).
- data_out  output  1  serial bit, registered.
- frame_start  output  1  high during the first (MSB) bit of every frame, registered.
- active  output  1  high once warm-up is complete, registered.

## Operation
- State:
  - bit_cnt: 3 bits, wraps 7→0.
  - sr: 8-bit shift register.
  - state: WARMUP or ACTIVE.
  - idle_cnt: wide enough to count to MIN_IDLE.
- Reset (reset=0, asynchronous, takes effect immediately):
  - data_out=0, frame_start=0, active=0.
  - bit_cnt=0, sr=0, idle_cnt=0, state=WARMUP.
- Load edge (bit_cnt==0):
  - Select sel = (state==ACTIVE && valid_in) ? data_in : IDLE_SYM.
  - data_out<=sel[7]; sr<={sel[6:0],1'b0}; frame_start<=1.
- Shift edge (bit_cnt 1..7):
  - data_out<=sr[7]; sr<=sr<<1; frame_start<=0.
- bit_cnt increments on every edge while out of reset.
- data_in and valid_in are sampled only on load edges. Changes to them mid-frame have no effect on the byte in flight.
- WARMUP:
  - Every load edge increments idle_cnt.
  - On the load edge where idle_cnt==MIN_IDLE-1, go to state ACTIVE and set active<=1 (same edge).
- ACTIVE:
  - Held until reset; active stays 1.
  - A frame with valid_in=0 transmits IDLE_SYM.
  - There is no backpressure.
- Reset mid-frame discards the partial byte. Warm-up restarts from idle_cnt=0 after release.

## Timing
- The first rising edge after reset release is a load edge. Subsequent load edges are every 8th edge (edges 1, 9, 17, …).
- Latency: the MSB of a sampled byte appears on data_out immediately after its load edge. The LSB appears after the 8th edge; the next frame follows back-to-back with no gap bit.
- Frame n (1-based) after release is always IDLE_SYM for n ≤ MIN_IDLE.
- active rises on load edge MIN_IDLE. The first frame that can carry data is loaded on edge 8·MIN_IDLE+1 (edge 33 for the default MIN_IDLE=4).
- frame_start is high for exactly 1 cycle in 8, aligned with the MSB.

## Test plan
- Hold reset=0 while driving valid_in=1, data_in=8'h11 for 20 cycles -> data_out=0, frame_start=0, active=0 throughout.
- Release reset with valid_in=1, data_in=8'hFF -> four frames of 1,0,1,1,1,1,0,0 (0xBC). active goes high after edge 25. Frame 5 (loaded on edge 33) is 1,1,1,1,1,1,1,1.
- In ACTIVE, drive data_in=8'h13, valid_in=1 -> serial 0,0,0,1,0,0,1,1 with frame_start=1 only on the first bit. Then drive 8'hFE -> 1,1,1,1,1,1,1,0 back-to-back.
- In ACTIVE, drive valid_in=0, data_in=8'h15 -> 0xBC transmitted, not 0x15. Then drive valid_in=1, data_in=8'h17 -> 0,0,0,1,0,1,1,1.
- With 8'hF9 loaded, change data_in to 8'h00 on bit 3 of the frame -> the frame still completes as 1,1,1,1,1,0,0,1.
- Assert reset=0 mid-frame (bit 4) in ACTIVE -> outputs drop to 0 immediately with no clock edge needed. After release, four 0xBC frames repeat before data resumes; active is low until edge 25.
